pow2_arbiter: RTL and testbench
===============================

Name: pow2_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pow2_fsm float-squaring unit between N requesters.
- Accepts one request at a time and drives the unit's x/r_i handshake.
- Holds x stable for the whole operation, captures res/err when r_o is seen, and returns the result to the granted requester.
- Adds a watchdog timeout and a post-reset drain window, because the unit itself has no reset.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 15, max cycles in WAIT for u_r_o before forcing an error completion.
- DRAIN, 6, cycles after reset before the first issue; must be at least the unit latency + 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level; held until that requester's ack.
- x_in  in  32*N  operand for requester i in bits [32i+31:32i]; stable while req[i] is high.
- ack  out  N  one-hot, 1-cycle pulse: request i accepted.
- done  out  N  one-hot, 1-cycle pulse: result for requester i valid on res_out/err_out.
- res_out  out  32  result word; registered, valid while done is high, held afterwards.
- err_out  out  1  overflow from the unit, or timeout; qualified by done.
- busy  out  1  high in any state other than IDLE.
- u_x  out  32  operand to the unit.
- u_r_i  out  1  start strobe to the unit.
- u_res  in  32  unit result.
- u_err  in  1  unit overflow flag.
- u_r_o  in  1  unit result-ready pulse.

Behaviour:
- Reset (rst high at a clock edge):
  - ack=0, done=0, res_out=0, err_out=0, u_x=0, u_r_i=0, busy=1.
  - Round-robin pointer = 0 (requester 0 has highest priority first).
  - State = DRAIN with drain counter = DRAIN.
- States:
  - DRAIN: decrement the counter each cycle; ignore u_r_o; go to IDLE when the counter reaches 0. This absorbs any operation in flight in the unit when reset hit mid-operation.
  - IDLE: if any req bit is set, pick the first set bit at or after the pointer, wrapping modulo N. Latch its index g, set u_x = x_in[g], pulse ack[g], go to ISSUE. busy=0 only in IDLE.
  - ISSUE: u_r_i=1 for exactly 1 cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - u_x is held unchanged, because the unit re-reads x during its last stage.
    - On u_r_o=1: capture res_out=u_res and err_out=u_err, then go to DONE.
    - Otherwise increment the counter. When it reaches TIMEOUT: res_out=0, err_out=1, go to DONE.
  - DONE: done[g]=1 for 1 cycle; pointer = (g+1) mod N; go to IDLE.
- Latency:
  - ack occurs 1 cycle after req is sampled in IDLE.
  - With pow2_fsm, done occurs 8 cycles after ack: 1 cycle ISSUE plus the unit's 5-cycle r_i to r_o latency, plus capture and DONE.
  - Back-to-back requests: IDLE re-arbitrates in the cycle after DONE, giving a minimum of 9 cycles per operation.
- Handshake rules:
  - The requester must keep req and x_in stable until ack.
  - The requester may drop req or change x_in after ack; the operand is already latched in u_x.
  - A requester may re-request immediately after its done. Round-robin guarantees every other pending requester is served first, so starvation is bounded at N-1 operations.
- Simultaneous events:
  - New req during a busy state: not acked until IDLE.
  - u_r_o outside WAIT: ignored, no done.
  - u_r_o in the same cycle the counter hits TIMEOUT: u_r_o wins, so the real result is delivered.
  - rst overrides everything. Results pending at reset are discarded and never produce done.
- Width rules:
  - Index g is clog2(N) bits.
  - The timeout counter is clog2(TIMEOUT+1) bits and saturates; it never wraps.
  - The drain counter is clog2(DRAIN+1) bits.

Decomposition:
- Shared package pow2_pkg holds:
  - the state encoding constants: DRAIN, IDLE, ISSUE, WAIT, DONE;
  - the float field constants: sign bit 31, exp [30:23], mant [22:0], bias 127.
- One natural sub-module: rr_pick. It is a combinational round-robin priority picker taking req and pointer and returning a one-hot grant, an index, and any_req. It is reusable for other shared units.

Test Plan:
- Single request: after reset, wait for DRAIN to expire, then req[0] with x_in[0]=0x40000000 (2.0). Expect ack[0], then done[0] with res_out=0x40800000 and err_out=0.
- Second operand: req[2] with x=0x3FC00000 (1.5). Expect done[2] with res_out=0x40100000 (2.25) and err_out=0.
- Round-robin: req=4'b1111 held continuously, each requester with a distinct operand. Expect the grant order 0,1,2,3,0. Each done carries the matching square. Exactly one ack and one done are high at any time.
- Timeout: drive the unit side from a stub that never asserts u_r_o. Expect done after TIMEOUT=15 WAIT cycles with res_out=0 and err_out=1. Then expect IDLE and normal service on the next request.
- Reset mid-operation: assert rst 2 cycles after u_r_i. Expect no done. Expect busy=1 for DRAIN cycles, and the stray u_r_o from the unit to be ignored. The next request returns the correct square.
- Holding: change x_in[1] and drop req[1] one cycle after ack[1]. Expect u_x unchanged through WAIT and the result equal to the square of the original operand.

Source files
------------

// File: rtl/pow2_pkg.sv
// Shared definitions for the pow2 squaring unit and its arbiter:
// sequencer state encoding and IEEE-754 single-precision field positions.
package pow2_pkg;

    typedef enum logic [2:0] {
        S_DRAIN = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;
    localparam int EXP_BIAS = 127;

endpackage

// File: rtl/pow2_arbiter_if.sv
// Requester bus and squaring-unit handshake shared by the arbiter (master)
// and the surrounding requesters/unit (slave).
interface pow2_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]    req;
    logic [32*N-1:0] x_in;
    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic [31:0]     res_out;
    logic            err_out;
    logic            busy;
    logic [31:0]     u_x;
    logic            u_r_i;
    logic [31:0]     u_res;
    logic            u_err;
    logic            u_r_o;

    modport master (
        input  req, x_in, u_res, u_err, u_r_o,
        output ack, done, res_out, err_out, busy, u_x, u_r_i
    );

    modport slave (
        output req, x_in, u_res, u_err, u_r_o,
        input  ack, done, res_out, err_out, busy, u_x, u_r_i
    );
endinterface

// File: rtl/pow2_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Reusable for any shared single-issue resource.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int IW = $clog2(N);

    logic [IW:0] pos_s;

    // Scan offsets 0..N-1 from the pointer and keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos_s   = '0;
        for (int i = 0; i < N; i++) begin
            pos_s = {1'b0, ptr_i} + (IW+1)'(i);
            if (pos_s >= (IW+1)'(N)) begin
                pos_s = pos_s - (IW+1)'(N);
            end else begin
                pos_s = pos_s;
            end
            if (!any_o && req_i[pos_s[IW-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos_s[IW-1:0];
            end else begin
                any_o = any_o;
            end
        end
        if (any_o) begin
            grant_o = N'(1) << idx_o;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/pow2_arbiter.sv
// Round-robin sequencer sharing one pow2 squaring unit among N requesters,
// with a watchdog and a post-reset drain window since the unit has no reset.
module pow2_arbiter
    import pow2_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 15,
    parameter int DRAIN   = 6
) (
    input  logic          clk,
    input  logic          rst,
    pow2_arbiter_if.master bus
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   g_q, g_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [N-1:0]    done_q, done_d;
    logic [31:0]     res_q, res_d;
    logic            err_q, err_d;
    logic [31:0]     ux_q, ux_d;
    logic            uri_q, uri_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    pick_grant_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_any_s;
    logic [31:0]     x_sel_s;

    rr_pick #(.N(N)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // Operand mux for the requester chosen by the picker.
    always_comb begin
        x_sel_s = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx_s == IW'(i)) begin
                x_sel_s = bus.x_in[32*i +: 32];
            end else begin
                x_sel_s = x_sel_s;
            end
        end
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = tcnt_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        ack_d   = '0;
        done_d  = '0;
        res_d   = res_q;
        err_d   = err_q;
        ux_d    = ux_q;
        uri_d   = 1'b0;
        case (state_q)
            S_DRAIN: begin
                dcnt_d = dcnt_q - DW'(1);
                if (dcnt_q <= DW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_IDLE: begin
                if (pick_any_s) begin
                    g_d     = pick_idx_s;
                    ux_d    = x_sel_s;
                    ack_d   = pick_grant_s;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                uri_d   = 1'b1;
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (bus.u_r_o) begin
                    res_d   = bus.u_res;
                    err_d   = bus.u_err;
                    state_d = S_DONE;
                end else begin
                    if (tcnt_q == TW'(TIMEOUT)) begin
                        tcnt_d = tcnt_q;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                    if (tcnt_d == TW'(TIMEOUT)) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                done_d = N'(1) << g_q;
                if (g_q == IW'(N - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = g_q + IW'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_DRAIN;
                dcnt_d  = DW'(DRAIN);
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DRAIN;
            dcnt_q  <= DW'(DRAIN);
            tcnt_q  <= '0;
            ptr_q   <= '0;
            g_q     <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            ux_q    <= '0;
            uri_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            res_q   <= res_d;
            err_q   <= err_d;
            ux_q    <= ux_d;
            uri_q   <= uri_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.done    = done_q;
    assign bus.res_out = res_q;
    assign bus.err_out = err_q;
    assign bus.busy    = busy_q;
    assign bus.u_x     = ux_q;
    assign bus.u_r_i   = uri_q;

endmodule

// File: tb/tb_pow2_arbiter.sv
// Directed bench for pow2_arbiter with a behavioural 5-cycle squaring-unit
// stub whose results come from a hand-computed operand table.
module tb_pow2_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 15;
    localparam int DRAIN   = 6;
    localparam int LAT     = 8;
    localparam int TO_LAT  = 17;
    localparam int BUDGET  = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pow2_arbiter_if #(.N(N)) bus ();

    pow2_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Unit stub: r_o five cycles after r_i, result read from x at r_o time.
    logic [4:0] pipe_r = 5'b00000;
    logic       stall  = 1'b0;

    function automatic logic [32:0] unit_sq(input logic [31:0] x);
        case (x)
            32'h40000000: unit_sq = {1'b0, 32'h40800000};
            32'h3FC00000: unit_sq = {1'b0, 32'h40100000};
            32'h40400000: unit_sq = {1'b0, 32'h41100000};
            32'h3F000000: unit_sq = {1'b0, 32'h3E800000};
            32'h40800000: unit_sq = {1'b0, 32'h41800000};
            32'h7F000000: unit_sq = {1'b1, 32'h7F800000};
            default:      unit_sq = {1'b0, 32'hFFFFFFFF};
        endcase
    endfunction

    always @(posedge clk) pipe_r <= {pipe_r[3:0], bus.u_r_i};
    assign bus.u_r_o = pipe_r[4] & ~stall;
    assign {bus.u_err, bus.u_res} = unit_sq(bus.u_x);

    int n_checks  = 0;
    int n_errs    = 0;
    int done_seen = 0;
    int multi_hot = 0;

    always @(negedge clk) begin
        if (bus.done != '0) done_seen <= done_seen + 1;
        if ($countones(bus.ack) > 1 || $countones(bus.done) > 1) multi_hot <= multi_hot + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack"},  64'(bus.ack),     64'd0);
        check({tag, "_done"}, 64'(bus.done),    64'd0);
        check({tag, "_res"},  64'(bus.res_out), 64'd0);
        check({tag, "_err"},  64'(bus.err_out), 64'd0);
        check({tag, "_ux"},   64'(bus.u_x),     64'd0);
        check({tag, "_uri"},  64'(bus.u_r_i),   64'd0);
        check({tag, "_busy"}, 64'(bus.busy),    64'd1);
    endtask

    // Called at the negedge of the first cycle after the reset edge.
    task automatic drain_check(input string tag);
        int hi;
        hi = 0;
        for (int k = 0; k < DRAIN; k++) begin
            if (bus.busy) hi++;
            @(negedge clk);
        end
        check({tag, "_drain_busy"}, 64'(hi), 64'(DRAIN));
        check({tag, "_drain_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic do_op(input string tag, input int idx, input logic [31:0] x,
                         input logic [31:0] exp_res, input logic exp_err,
                         input int exp_lat, input bit hold_test);
        int n;
        int lat;
        int ux_bad;
        bus.x_in[32*idx +: 32] = x;
        bus.req[idx] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == '0 && n < BUDGET);
        check({tag, "_ack"}, 64'(bus.ack), 64'(4'b0001 << idx));
        check({tag, "_ack_lat"}, 64'(n), 64'd1);
        if (!hold_test) bus.req[idx] = 1'b0;
        lat = 0;
        ux_bad = 0;
        do begin
            @(negedge clk);
            lat++;
            if (hold_test && lat == 1) begin
                bus.req[idx] = 1'b0;
                bus.x_in[32*idx +: 32] = 32'h40800000;
            end
            if (bus.u_x !== x) ux_bad++;
        end while (bus.done == '0 && lat < BUDGET);
        check({tag, "_done"},    64'(bus.done),    64'(4'b0001 << idx));
        check({tag, "_lat"},     64'(lat),         64'(exp_lat));
        check({tag, "_res"},     64'(bus.res_out), 64'(exp_res));
        check({tag, "_err"},     64'(bus.err_out), 64'(exp_err));
        check({tag, "_ux_hold"}, 64'(ux_bad),      64'd0);
    endtask

    int          n;
    int          saved;
    int          order [5] = '{0, 1, 2, 3, 0};
    logic [31:0] rr_res [4] = '{32'h40800000, 32'h40100000, 32'h41100000, 32'h3E800000};

    initial begin
        bus.req  = '0;
        bus.x_in = '0;

        @(negedge clk);
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        drain_check("reset");

        // Round-robin with all four requesters held high.
        bus.x_in = {32'h3F000000, 32'h40400000, 32'h3FC00000, 32'h40000000};
        bus.req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.ack == '0 && n < BUDGET);
            check($sformatf("rr%0d_ack", k), 64'(bus.ack), 64'(4'b0001 << order[k]));
            if (k == 4) bus.req = 4'b0000;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.done == '0 && n < BUDGET);
            check($sformatf("rr%0d_done", k), 64'(bus.done), 64'(4'b0001 << order[k]));
            check($sformatf("rr%0d_lat", k),  64'(n), 64'(LAT));
            check($sformatf("rr%0d_res", k),  64'(bus.res_out), 64'(rr_res[order[k]]));
            check($sformatf("rr%0d_err", k),  64'(bus.err_out), 64'd0);
        end

        do_op("single0", 0, 32'h40000000, 32'h40800000, 1'b0, LAT, 1'b0);
        do_op("second2", 2, 32'h3FC00000, 32'h40100000, 1'b0, LAT, 1'b0);
        do_op("ovf3",    3, 32'h7F000000, 32'h7F800000, 1'b1, LAT, 1'b0);
        do_op("hold1",   1, 32'h40400000, 32'h41100000, 1'b0, LAT, 1'b1);

        stall = 1'b1;
        do_op("timeout0", 0, 32'h40000000, 32'h00000000, 1'b1, TO_LAT, 1'b0);
        stall = 1'b0;
        do_op("after_to1", 1, 32'h3FC00000, 32'h40100000, 1'b0, LAT, 1'b0);

        // Reset two cycles after the start strobe; the result must be dropped.
        bus.x_in[64 +: 32] = 32'h3F000000;
        bus.req[2] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == '0 && n < BUDGET);
        check("rstmid_ack", 64'(bus.ack), 64'(4'b0100));
        bus.req[2] = 1'b0;
        @(negedge clk);
        check("rstmid_uri", 64'(bus.u_r_i), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        saved = done_seen;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rstmid");
        drain_check("rstmid");
        repeat (10) @(negedge clk);
        check("rstmid_no_done", 64'(done_seen - saved), 64'd0);
        do_op("after_rst3", 3, 32'h40400000, 32'h41100000, 1'b0, LAT, 1'b0);

        check("onehot_ack_done", 64'(multi_hot), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
